// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
//
// Streaming signed multiply-accumulate cell. Each enabled cycle supplies
// one data/weight pair. The cell multiplies the pair, sums VECTOR_LENGTH
// products, and presents each finished sum for a single cycle as
// {valid, result}. It feeds relu_cell directly.
//
// Pipeline:
//   stage 1 - register the full-precision signed product, sign-extended to
//             RESULT_WIDTH, together with a product_valid flag
//   stage 2 - accumulate the registered products and emit the sum on the
//             last element of each vector
//
// Ports:
//   clk           system clock, rising-edge active
//   reset         asynchronous active-high reset, clears all state
//   input_data    signed operand A (DATA_WIDTH)
//   input_weight  signed operand B (DATA_WIDTH)
//   input_enable  operand pair valid this cycle
//   output_result bit [RESULT_WIDTH] = valid,
//                 bits [RESULT_WIDTH-1:0] = signed sum (zero when not valid)

module dot_product_accumulator #(
    parameter int DATA_WIDTH    = 32,
    parameter int RESULT_WIDTH  = 64,
    parameter int VECTOR_LENGTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   input_data,
    input  logic [DATA_WIDTH-1:0]   input_weight,
    input  logic                    input_enable,
    output logic [RESULT_WIDTH:0]   output_result
);

    // A one-element vector still needs a one-bit counter so that the
    // declarations stay legal; the counter then never leaves zero.
    localparam int COUNT_WIDTH = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(VECTOR_LENGTH - 1);

    logic signed [2*DATA_WIDTH-1:0]   data_ext;
    logic signed [2*DATA_WIDTH-1:0]   weight_ext;
    logic signed [2*DATA_WIDTH-1:0]   full_product;
    logic signed [RESULT_WIDTH-1:0]   product_wide;

    logic        [RESULT_WIDTH-1:0]   product;
    logic                             product_valid;
    logic        [RESULT_WIDTH-1:0]   acc;
    logic        [RESULT_WIDTH-1:0]   acc_sum;
    logic        [COUNT_WIDTH-1:0]    count;
    logic                             last_element;

    // Operands are sign-extended to double width before multiplying so the
    // low 2*DATA_WIDTH bits of the product are the exact signed result,
    // which is then sign-extended again to the accumulator width.
    always_comb begin
        data_ext     = {{DATA_WIDTH{input_data[DATA_WIDTH-1]}}, input_data};
        weight_ext   = {{DATA_WIDTH{input_weight[DATA_WIDTH-1]}}, input_weight};
        full_product = data_ext * weight_ext;
        product_wide = RESULT_WIDTH'(full_product);
    end

    // Stage 1: product register. The product value is only meaningful when
    // product_valid is set, but it is loaded only on enabled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            product       <= '0;
            product_valid <= 1'b0;
        end else begin
            product_valid <= input_enable;
            if (input_enable) begin
                product <= product_wide;
            end
        end
    end

    // Two's complement sum wraps modulo 2^RESULT_WIDTH by construction.
    always_comb begin
        acc_sum      = acc + product;
        last_element = (count == LAST_COUNT);
    end

    // Stage 2: accumulate. Idle cycles hold the partial sum and count so a
    // vector may be spread over arbitrary gaps. The last element emits the
    // sum and restarts at zero, allowing back-to-back vectors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc           <= '0;
            count         <= '0;
            output_result <= '0;
        end else begin
            output_result <= '0;
            if (product_valid) begin
                if (last_element) begin
                    output_result <= {1'b1, acc_sum};
                    acc           <= '0;
                    count         <= '0;
                end else begin
                    acc   <= acc_sum;
                    count <= count + COUNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb_dot_product_accumulator
//
// Directed bench for dot_product_accumulator with VECTOR_LENGTH=3.
// The stimulus side queues each hand-computed sum together with the cycle
// on which it must appear; an independent monitor compares the output on
// every falling edge, requiring the queued value on its due cycle and an
// all-zero bus on every other cycle.

module tb_dot_product_accumulator;

    localparam int DATA_WIDTH    = 32;
    localparam int RESULT_WIDTH  = 64;
    localparam int VECTOR_LENGTH = 3;

    typedef struct {
        logic [RESULT_WIDTH:0] value;
        int                    due_cycle;
    } expect_t;

    logic                  clk;
    logic                  reset;
    logic [DATA_WIDTH-1:0] input_data;
    logic [DATA_WIDTH-1:0] input_weight;
    logic                  input_enable;
    logic [RESULT_WIDTH:0] output_result;

    expect_t expect_queue[$];
    int      cycle_count;
    int      compared;
    int      mismatched;
    bit      monitor_on;

    dot_product_accumulator #(
        .DATA_WIDTH   (DATA_WIDTH),
        .RESULT_WIDTH (RESULT_WIDTH),
        .VECTOR_LENGTH(VECTOR_LENGTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .input_data   (input_data),
        .input_weight (input_weight),
        .input_enable (input_enable),
        .output_result(output_result)
    );

    // 20 ns clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Rising edges seen so far; used to timestamp expected results.
    initial cycle_count = 0;
    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic checkOutput(input string name,
                               input logic [RESULT_WIDTH:0] actual,
                               input logic [RESULT_WIDTH:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h",
                     name, cycle_count, actual, required);
        end
    endtask

    // Drive one cycle of input on the falling edge; the DUT samples it on
    // the following rising edge.
    task automatic applyStimulus(input logic signed [DATA_WIDTH-1:0] d,
                                 input logic signed [DATA_WIDTH-1:0] w,
                                 input logic en);
        @(negedge clk);
        input_data   = d;
        input_weight = w;
        input_enable = en;
    endtask

    // Called right after the last element of a vector has been driven:
    // sampled at the next edge E, visible after edge E+1.
    task automatic expectResult(input logic signed [RESULT_WIDTH-1:0] sum);
        expect_t e;
        e.value     = {1'b1, sum};
        e.due_cycle = cycle_count + 2;
        expect_queue.push_back(e);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus('0, '0, 1'b0);
        end
    endtask

    // Monitor: the front entry is due exactly on its cycle; every other
    // cycle the bus must be fully zero.
    always @(negedge clk) begin
        if (monitor_on) begin
            if (expect_queue.size() > 0 && expect_queue[0].due_cycle <= cycle_count) begin
                checkOutput("result", output_result, expect_queue[0].value);
                void'(expect_queue.pop_front());
            end else begin
                checkOutput("idle_zero", output_result, '0);
            end
        end
    end

    initial begin
        compared     = 0;
        mismatched   = 0;
        monitor_on   = 1'b0;
        input_data   = '0;
        input_weight = '0;
        input_enable = 1'b0;
        reset        = 1'b1;

        #1;
        checkOutput("reset_state", output_result, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        monitor_on = 1'b1;

        $display("[TB] basic vector");
        applyStimulus(2, 3, 1'b1);
        applyStimulus(4, 5, 1'b1);
        applyStimulus(6, 1, 1'b1);
        expectResult(64'sd32);
        idleCycles(4);

        $display("[TB] negative sum");
        applyStimulus(-5, 4, 1'b1);
        applyStimulus(1, 1, 1'b1);
        applyStimulus(0, 7, 1'b1);
        expectResult(64'shFFFF_FFFF_FFFF_FFED);
        idleCycles(4);

        $display("[TB] gaps between elements");
        applyStimulus(2, 3, 1'b1);
        idleCycles(2);
        applyStimulus(4, 5, 1'b1);
        idleCycles(2);
        applyStimulus(6, 1, 1'b1);
        expectResult(64'sd32);
        idleCycles(4);

        $display("[TB] back-to-back vectors");
        applyStimulus(1, 1, 1'b1);
        applyStimulus(1, 2, 1'b1);
        applyStimulus(1, 3, 1'b1);
        expectResult(64'sd6);
        applyStimulus(2, 2, 1'b1);
        applyStimulus(2, 2, 1'b1);
        applyStimulus(2, 2, 1'b1);
        expectResult(64'sd12);
        idleCycles(4);

        $display("[TB] reset mid-vector");
        applyStimulus(10, 10, 1'b1);
        applyStimulus(10, 10, 1'b1);
        applyStimulus(0, 0, 1'b0);
        #3 reset = 1'b1;
        #1 checkOutput("async_reset", output_result, '0);
        #2 reset = 1'b0;
        applyStimulus(1, 1, 1'b1);
        applyStimulus(1, 1, 1'b1);
        applyStimulus(1, 1, 1'b1);
        expectResult(64'sd3);
        idleCycles(4);

        $display("[TB] wrap-around");
        applyStimulus(32'sh8000_0000, 32'sh8000_0000, 1'b1);
        applyStimulus(32'sh8000_0000, 32'sh8000_0000, 1'b1);
        applyStimulus(32'sh8000_0000, 32'sh8000_0000, 1'b1);
        expectResult(64'shC000_0000_0000_0000);
        idleCycles(5);

        compared++;
        if (expect_queue.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d results never appeared, expected 0",
                     expect_queue.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Streaming signed multiply-accumulate cell that produces the result bus consumed by `relu_cell`. It multiplies paired data/weight words, sums VECTOR_LENGTH products, and emits each finished sum as a one-cycle valid result. The output is `{valid, result}`, RESULT_WIDTH+1 bits wide. It sits directly upstream of `relu_cell` in each neuron column.

## Interface

Parameters:
- DATA_WIDTH, 32, width of the signed data and weight operands
- RESULT_WIDTH, 64, width of the signed product and accumulator; must be ≥ 2*DATA_WIDTH
- VECTOR_LENGTH, 4, number of products summed per output; ≥ 1

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- input_data  input  DATA_WIDTH  signed operand A
- input_weight  input  DATA_WIDTH  signed operand B
- input_enable  input  1  operand pair is valid this cycle
- output_result  output  RESULT_WIDTH+1  bit [RESULT_WIDTH] = valid; bits [RESULT_WIDTH-1:0] = signed sum

## Operation

- Stage 1 (product register):
  - On each edge with input_enable=1, register the full-precision signed product input_data*input_weight, sign-extended to RESULT_WIDTH.
  - Register product_valid=1 alongside it.
  - With input_enable=0, product_valid<=0 and the product register is don't-care.
- Stage 2 (accumulate):
  - Element counter runs 0..VECTOR_LENGTH-1 and advances only on edges with product_valid=1.
  - When product_valid=1 and count<VECTOR_LENGTH-1: acc<=acc+product, count<=count+1, output_result<=0.
  - When product_valid=1 and count=VECTOR_LENGTH-1 (last element):
    - output_result<={1'b1, acc+product}
    - acc<=0, count<=0
  - When product_valid=0: acc and count hold, output_result<=0.
- output_result is fully zero whenever valid=0; the result bits never hold a stale sum.
- Arithmetic: two's complement. The sum wraps modulo 2^RESULT_WIDTH with no saturation and no overflow flag.
- VECTOR_LENGTH=1: every product is the last element, so each enabled input yields its own valid output.
- Back-to-back vectors: no idle cycle is required between vectors. The first element of the next vector may follow the last element of the previous one on the very next cycle; it accumulates from 0.
- Gaps: input_enable may drop at any point mid-vector. The partial sum and count are held indefinitely.
- Reset, asynchronous and at any time including mid-vector:
  - Clears product register, product_valid, acc, count and output_result to 0.
  - Any partial sum is discarded.
  - The first enabled pair after reset deasserts is element 0 of a new vector.

## Timing

- Reset values: output_result=0 (valid=0, result=0). Internal acc=0, count=0, product_valid=0.
- Latency: the last element of a vector is sampled at edge E. output_result is valid for exactly one cycle, from after edge E+1 until edge E+2.
- Throughput: one operand pair per cycle, sustained, including across vector boundaries.
- Valid pulses are exactly VECTOR_LENGTH enabled cycles apart when input is continuous.
- output_result is registered and can feed `relu_cell.input_result` with no glue logic.
- Critical path: one DATA_WIDTH×DATA_WIDTH multiply in stage 1 and one RESULT_WIDTH add in stage 2. Nothing is chained combinationally.

## Test plan

All scenarios use DATA_WIDTH=32, RESULT_WIDTH=64, VECTOR_LENGTH=3, and a 20 ns clock.

1. Basic: pairs (2,3), (4,5), (6,1) on consecutive cycles with enable=1 -> output_result valid=1 with value 32, two edges after the third sample, for exactly one cycle. It is 0 on all other cycles.
2. Negative sum: pairs (-5,4), (1,1), (0,7) -> valid=1 with value -19 (0xFFFF_FFFF_FFFF_FFED). When chained into `relu_cell`, the downstream value is 0.
3. Gaps: the scenario-1 pairs with enable low for 2 cycles between each pair -> no valid until the third enabled pair, then 32 at the same two-edge latency.
4. Back-to-back: six consecutive pairs (1,1), (1,2), (1,3), (2,2), (2,2), (2,2) -> valid 6 then valid 12, exactly 3 cycles apart. The second sum is unaffected by the first.
5. Reset mid-vector: two pairs (10,10), (10,10), then reset pulsed high asynchronously mid-cycle -> output_result reads 0 immediately. Then (1,1), (1,1), (1,1) -> valid 3, not 203.
6. Wrap: three pairs (-2^31, -2^31) -> valid=1 with value 0xC000_0000_0000_0000, the modulo-2^64 sum of 3·2^62. There is no saturation.
